// File: rtl/note_dispenser.sv
// Note dispenser: turns a requested amount into one pulse per 5000, 2000 and 1000 note.
// A greedy plan runs first, one subtraction per cycle, limited by the latched stock counts.
// The planned notes are then emitted 5000s first, then 2000s, then 1000s.
//
// Optional feature: define DISPENSE_ABORT_EN to add the `abort` input. An abort during
// PLAN, EMIT_HI or EMIT_LO ends the request through ERR. Notes already emitted stay counted.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   start             request strobe, sampled only in IDLE
//   abort             (DISPENSE_ABORT_EN only) cancels the running request
//   amount            requested value, latched on an accepted start
//   stock_5000/2000/1000  available notes, latched on an accepted start
//   pulse5000/2000/1000   note pulses, PULSE_HI cycles high with PULSE_LO cycles low between
//   n_5000/2000/1000  notes emitted in the current or last request
//   busy              high in every state except IDLE
//   done / error      one-cycle completion / failure pulses
module note_dispenser #(
  parameter int unsigned PULSE_HI = 2,
  parameter int unsigned PULSE_LO = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef DISPENSE_ABORT_EN
  input  logic        abort,
`endif
  input  logic [18:0] amount,
  input  logic [6:0]  stock_5000,
  input  logic [7:0]  stock_2000,
  input  logic [8:0]  stock_1000,
  output logic        pulse5000,
  output logic        pulse2000,
  output logic        pulse1000,
  output logic [6:0]  n_5000,
  output logic [7:0]  n_2000,
  output logic [8:0]  n_1000,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CntMax = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HiLast = CntW'(PULSE_HI - 1);
  localparam logic [CntW-1:0] LoLast = CntW'(PULSE_LO - 1);

  typedef enum logic [2:0] {StIdle, StPlan, StEmitHi, StEmitLo, StFin, StErr} state_e;

  state_e          state_q, state_d;
  logic [18:0]     rem_q, rem_d;
  logic [6:0]      s5_q, s5_d, p5_q, p5_d, n5_q, n5_d;
  logic [7:0]      s2_q, s2_d, p2_q, p2_d, n2_q, n2_d;
  logic [8:0]      s1_q, s1_d, p1_q, p1_d, n1_q, n1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            p5k_q, p2k_q, p1k_q, p5k_d, p2k_d, p1k_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;

  // Denomination being emitted: first nonzero plan count, largest note first.
  logic sel5, sel2, any_p;
  assign sel5  = (p5_q != '0);
  assign sel2  = (p5_q == '0) && (p2_q != '0);
  assign any_p = (p5_q != '0) || (p2_q != '0) || (p1_q != '0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    s5_d    = s5_q;
    s2_d    = s2_q;
    s1_d    = s1_q;
    p5_d    = p5_q;
    p2_d    = p2_q;
    p1_d    = p1_q;
    n5_d    = n5_q;
    n2_d    = n2_q;
    n1_d    = n1_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          rem_d   = amount;
          s5_d    = stock_5000;
          s2_d    = stock_2000;
          s1_d    = stock_1000;
          p5_d    = '0;
          p2_d    = '0;
          p1_d    = '0;
          n5_d    = '0;
          n2_d    = '0;
          n1_d    = '0;
          state_d = StPlan;
        end
      end
      StPlan: begin
        // Each compare guards its subtraction, so rem never underflows.
        if (rem_q >= 19'd5000 && p5_q < s5_q) begin
          rem_d = rem_q - 19'd5000;
          p5_d  = p5_q + 7'd1;
        end else if (rem_q >= 19'd2000 && p2_q < s2_q) begin
          rem_d = rem_q - 19'd2000;
          p2_d  = p2_q + 8'd1;
        end else if (rem_q >= 19'd1000 && p1_q < s1_q) begin
          rem_d = rem_q - 19'd1000;
          p1_d  = p1_q + 9'd1;
        end else if (rem_q == '0) begin
          cnt_d   = '0;
          state_d = any_p ? StEmitHi : StFin;
        end else begin
          state_d = StErr;
        end
      end
      StEmitHi: begin
        if (cnt_q == '0) begin
          if (sel5)      n5_d = n5_q + 7'd1;
          else if (sel2) n2_d = n2_q + 8'd1;
          else           n1_d = n1_q + 9'd1;
        end
        if (cnt_q == HiLast) begin
          if (sel5)      p5_d = p5_q - 7'd1;
          else if (sel2) p2_d = p2_q - 8'd1;
          else           p1_d = p1_q - 9'd1;
          cnt_d   = '0;
          state_d = StEmitLo;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEmitLo: begin
        if (cnt_q == LoLast) begin
          cnt_d   = '0;
          state_d = any_p ? StEmitHi : StFin;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef DISPENSE_ABORT_EN
    // Abort wins over this cycle's work; only notes already counted are kept.
    if (abort && (state_q == StPlan || state_q == StEmitHi || state_q == StEmitLo)) begin
      state_d = StErr;
      rem_d   = rem_q;
      p5_d    = p5_q;
      p2_d    = p2_q;
      p1_d    = p1_q;
      n5_d    = n5_q;
      n2_d    = n2_q;
      n1_d    = n1_q;
      cnt_d   = '0;
    end
`endif

    // Outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFin);
    error_d = (state_d == StErr);
    p5k_d   = (state_d == StEmitHi) && (p5_d != '0);
    p2k_d   = (state_d == StEmitHi) && (p5_d == '0) && (p2_d != '0);
    p1k_d   = (state_d == StEmitHi) && (p5_d == '0) && (p2_d == '0) && (p1_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      s5_q    <= '0;
      s2_q    <= '0;
      s1_q    <= '0;
      p5_q    <= '0;
      p2_q    <= '0;
      p1_q    <= '0;
      n5_q    <= '0;
      n2_q    <= '0;
      n1_q    <= '0;
      cnt_q   <= '0;
      p5k_q   <= 1'b0;
      p2k_q   <= 1'b0;
      p1k_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      s5_q    <= s5_d;
      s2_q    <= s2_d;
      s1_q    <= s1_d;
      p5_q    <= p5_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      n5_q    <= n5_d;
      n2_q    <= n2_d;
      n1_q    <= n1_d;
      cnt_q   <= cnt_d;
      p5k_q   <= p5k_d;
      p2k_q   <= p2k_d;
      p1k_q   <= p1k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign pulse5000 = p5k_q;
  assign pulse2000 = p2k_q;
  assign pulse1000 = p1k_q;
  assign n_5000    = n5_q;
  assign n_2000    = n2_q;
  assign n_1000    = n1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_note_dispenser.sv
// Self-checking bench for note_dispenser: directed requests plus randomized ones, each
// checked against a greedy plan computed with plain division and a cycle-count model.
module tb_note_dispenser;

  localparam int PHI = 2;
  localparam int PLO = 2;

  logic        clk, rst, start, abort;
  logic [18:0] amount;
  logic [6:0]  stock_5000;
  logic [7:0]  stock_2000;
  logic [8:0]  stock_1000;
  logic        pulse5000, pulse2000, pulse1000, busy, done, error;
  logic [6:0]  n_5000;
  logic [7:0]  n_2000;
  logic [8:0]  n_1000;

  int n_cmp = 0;
  int n_bad = 0;

  note_dispenser #(.PULSE_HI(PHI), .PULSE_LO(PLO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef DISPENSE_ABORT_EN
    .abort     (abort),
`endif
    .amount    (amount),
    .stock_5000(stock_5000),
    .stock_2000(stock_2000),
    .stock_1000(stock_1000),
    .pulse5000 (pulse5000),
    .pulse2000 (pulse2000),
    .pulse1000 (pulse1000),
    .n_5000    (n_5000),
    .n_2000    (n_2000),
    .n_1000    (n_1000),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Greedy plan: take as many of each note as amount and stock allow, largest first.
  function automatic void plan(input int amt, input int s5, input int s2, input int s1,
                               output int k5, output int k2, output int k1, output bit ok);
    int r;
    r  = amt;
    k5 = r / 5000; if (k5 > s5) k5 = s5; r = r - k5 * 5000;
    k2 = r / 2000; if (k2 > s2) k2 = s2; r = r - k2 * 2000;
    k1 = r / 1000; if (k1 > s1) k1 = s1; r = r - k1 * 1000;
    ok = (r == 0);
  endfunction

  function automatic int denom(input logic [2:0] v);
    if (v == 3'b100) return 5000;
    if (v == 3'b010) return 2000;
    return 1000;
  endfunction

  task automatic run_req(input string name, input int amt, input int s5, input int s2,
                         input int s1, input bit hold);
    int k5, k2, k1, nn, exp_lat, cyc, hi_len, lo_len, width_err, ovl_err, order_err;
    bit ok, in_hi, seen, fin;
    logic first_busy;
    logic [2:0] vec, prev_vec;
    int exp_q[$];
    int obs_q[$];
    plan(amt, s5, s2, s1, k5, k2, k1, ok);
    if (!ok) begin k5 = 0; k2 = 0; k1 = 0; end
    for (int i = 0; i < k5; i++) exp_q.push_back(5000);
    for (int i = 0; i < k2; i++) exp_q.push_back(2000);
    for (int i = 0; i < k1; i++) exp_q.push_back(1000);
    // Plan subtractions still happen before an error is found.
    begin
      int p5, p2, p1;
      bit okp;
      plan(amt, s5, s2, s1, p5, p2, p1, okp);
      nn = p5 + p2 + p1;
    end
    exp_lat = ok ? nn + 2 + nn * (PHI + PLO) : nn + 2;

    @(negedge clk);
    amount = 19'(amt); stock_5000 = 7'(s5); stock_2000 = 8'(s2); stock_1000 = 9'(s1);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    else begin
      amount = 19'($urandom); stock_5000 = 7'($urandom);
      stock_2000 = 8'($urandom); stock_1000 = 9'($urandom);
    end
    first_busy = busy;
    cyc = 1; hi_len = 0; lo_len = 0; width_err = 0; ovl_err = 0; order_err = 0;
    in_hi = 0; seen = 0; fin = 0; prev_vec = '0;
    while (!fin && cyc < 5000) begin
      vec = {pulse5000, pulse2000, pulse1000};
      if ($countones(vec) > 1) ovl_err++;
      if (vec != '0) begin
        if (!in_hi) begin
          if (seen && lo_len != PLO) width_err++;
          seen = 1; in_hi = 1; hi_len = 1; prev_vec = vec;
          obs_q.push_back(denom(vec));
        end else begin
          hi_len++;
          if (vec != prev_vec) ovl_err++;
        end
      end else if (in_hi) begin
        if (hi_len != PHI) width_err++;
        in_hi = 0; lo_len = 1;
      end else begin
        lo_len++;
      end
      if (done === 1'b1 || error === 1'b1) fin = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, ":busy_rise"}, 32'(first_busy), 32'd1);
    check({name, ":done"}, 32'(done), 32'(ok));
    check({name, ":error"}, 32'(error), 32'(!ok));
    check({name, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({name, ":n_5000"}, 32'(n_5000), 32'(k5));
    check({name, ":n_2000"}, 32'(n_2000), 32'(k2));
    check({name, ":n_1000"}, 32'(n_1000), 32'(k1));
    check({name, ":pulse_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] != exp_q[i]) order_err++;
    check({name, ":order_err"}, 32'(order_err), 32'd0);
    check({name, ":width_err"}, 32'(width_err), 32'd0);
    check({name, ":overlap_err"}, 32'(ovl_err), 32'd0);
    if (hold) start = 1'b0;
    @(negedge clk);
    check({name, ":idle_after"}, 32'({busy, done, error}), 32'd0);
    check({name, ":n_hold"}, 32'({n_5000, n_2000, n_1000}),
          32'({7'(k5), 8'(k2), 9'(k1)}));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    amount = '0; stock_5000 = '0; stock_2000 = '0; stock_1000 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({pulse5000, pulse2000, pulse1000, busy, done, error,
                             n_5000, n_2000, n_1000}), 32'd0);
    rst = 1'b1;

    run_req("r17000", 17000, 127, 255, 511, 1'b0);
    run_req("r170000", 170000, 20, 255, 511, 1'b0);
    run_req("r170584", 170584, 127, 255, 511, 1'b0);
    run_req("r6000_greedy", 6000, 1, 3, 0, 1'b0);
    run_req("r0", 0, 127, 255, 511, 1'b0);
    run_req("hold17000", 17000, 127, 255, 511, 1'b1);

    // Reset during the second 5000 pulse.
    @(negedge clk);
    amount = 19'd17000; stock_5000 = 7'd127; stock_2000 = 8'd255; stock_1000 = 9'd511;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && pulse5000 !== 1'b1; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("midrst:pulse_pre", 32'(pulse5000), 32'd1);
    check("midrst:n5000_pre", 32'(n_5000), 32'd1);
    #2 rst = 1'b0;
    #1 check("midrst:outs_async", 32'({pulse5000, pulse2000, pulse1000, busy, done, error,
                                       n_5000, n_2000, n_1000}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_req("after_rst", 9000, 127, 255, 511, 1'b0);

`ifdef DISPENSE_ABORT_EN
    @(negedge clk);
    amount = 19'd17000; stock_5000 = 7'd127; stock_2000 = 8'd255; stock_1000 = 9'd511;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && pulse5000 !== 1'b1; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort:error", 32'(error), 32'd1);
    check("abort:pulses", 32'({pulse5000, pulse2000, pulse1000}), 32'd0);
    check("abort:n_5000", 32'(n_5000), 32'd2);
    @(negedge clk);
    check("abort:idle", 32'({busy, error}), 32'd0);
`endif

    for (int i = 0; i < 25; i++) begin
      int amt;
      if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 60000));
      else amt = 1000 * int'($urandom_range(0, 60));
      run_req($sformatf("rnd%0d", i), amt, int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
